// File: rtl/ex_stage_md.sv
// Execute stage with valid/stall/flush control, single-cycle RV32M multiply and a
// radix-2 restoring divider that back-pressures ID through ex_busy.
module ex_stage_md #(
  parameter int XLEN     = 32,
  parameter int RF_AW    = 5,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic                id_reg_wen,
  input  logic [RF_AW-1:0]    id_reg_waddr,
  input  logic [XLEN-1:0]     id_rs1_data,
  input  logic [XLEN-1:0]     id_rs2_data,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                id_md_en,
  input  logic [2:0]          id_md_op,
  input  logic                id_ill_instr,
  input  logic                ex_flush,
  input  logic                ex_stall_in,
  output logic                ex_busy,
  output logic                ex_valid,
  output logic                ex_reg_wen,
  output logic [RF_AW-1:0]    ex_reg_waddr,
  output logic [XLEN-1:0]     ex_result,
  output logic                ex_ill_instr
);

  localparam int CNT_W = $clog2(XLEN);
  localparam int SH_W  = $clog2(XLEN);

  // ALU encoding is {funct7[5], funct3}
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(13);

  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

  // div_state is the FSM state observed by checkers
  div_state_e      div_state, div_state_nxt;
  logic [CNT_W-1:0] div_cnt;
  logic [XLEN-1:0] div_quo, div_rem, div_dvsr;
  logic            div_q_neg, div_r_neg;

  logic [XLEN-1:0] alu_res, mul_res, div_res, ex_result_nxt;
  logic [SH_W-1:0] shamt;
  logic            mul_a_sgn, mul_b_sgn;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
  logic            div_signed, dvd_neg, dvs_neg, div_start, div_by_zero, div_ovf;
  logic [XLEN-1:0] dvd_abs, dvs_abs, q_out, r_out;
  logic [XLEN:0]   div_trial;
  logic            load_valid;

  // ALU
  assign shamt = id_rs2_data[SH_W-1:0];
  always_comb begin
    alu_res = '0;
    case (id_alu_op)
      ALU_ADD:  alu_res = id_rs1_data + id_rs2_data;
      ALU_SUB:  alu_res = id_rs1_data - id_rs2_data;
      ALU_SLL:  alu_res = id_rs1_data << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(id_rs1_data) < $signed(id_rs2_data)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, id_rs1_data < id_rs2_data};
      ALU_XOR:  alu_res = id_rs1_data ^ id_rs2_data;
      ALU_SRL:  alu_res = id_rs1_data >> shamt;
      ALU_SRA:  alu_res = XLEN'($signed(id_rs1_data) >>> shamt);
      ALU_OR:   alu_res = id_rs1_data | id_rs2_data;
      ALU_AND:  alu_res = id_rs1_data & id_rs2_data;
      default:  alu_res = '0;
    endcase
  end

  // Multiplier: sign-extend to 2*XLEN so one unsigned product covers all four ops
  assign mul_a_sgn = (id_md_op[1:0] == 2'd1) || (id_md_op[1:0] == 2'd2);
  assign mul_b_sgn = (id_md_op[1:0] == 2'd1);
  assign mul_a     = {{XLEN{mul_a_sgn & id_rs1_data[XLEN-1]}}, id_rs1_data};
  assign mul_b     = {{XLEN{mul_b_sgn & id_rs2_data[XLEN-1]}}, id_rs2_data};
  assign mul_p     = mul_a * mul_b;
  assign mul_res   = (id_md_op[1:0] == 2'd0) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];

  // Divider operand preparation
  assign div_signed  = ~id_md_op[0];
  assign dvd_neg     = div_signed & id_rs1_data[XLEN-1];
  assign dvs_neg     = div_signed & id_rs2_data[XLEN-1];
  assign dvd_abs     = dvd_neg ? -id_rs1_data : id_rs1_data;
  assign dvs_abs     = dvs_neg ? -id_rs2_data : id_rs2_data;
  assign div_by_zero = (id_rs2_data == '0);
  assign div_ovf     = div_signed && (id_rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                       && (id_rs2_data == '1);
  assign div_start   = rst_n & id_valid & id_md_en & id_md_op[2] & ~ex_flush;
  // MSB set means the shifted remainder was smaller than the divisor
  assign div_trial   = {div_rem, div_quo[XLEN-1]} - {1'b0, div_dvsr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_state <= DIV_IDLE;
      div_cnt   <= '0;
      div_quo   <= '0;
      div_rem   <= '0;
      div_dvsr  <= '0;
      div_q_neg <= 1'b0;
      div_r_neg <= 1'b0;
    end else begin
      div_state <= div_state_nxt;
      if (div_state == DIV_IDLE && div_start) begin
        div_cnt  <= '0;
        div_dvsr <= dvs_abs;
        if (div_by_zero) begin
          div_quo   <= '1;
          div_rem   <= id_rs1_data;
          div_q_neg <= 1'b0;
          div_r_neg <= 1'b0;
        end else if (div_ovf) begin
          div_quo   <= id_rs1_data;
          div_rem   <= '0;
          div_q_neg <= 1'b0;
          div_r_neg <= 1'b0;
        end else begin
          div_quo   <= dvd_abs;
          div_rem   <= '0;
          div_q_neg <= dvd_neg ^ dvs_neg;
          div_r_neg <= dvd_neg;
        end
      end else if (div_state == DIV_RUN) begin
        div_cnt <= div_cnt + CNT_W'(1);
        if (!div_trial[XLEN]) begin
          div_rem <= div_trial[XLEN-1:0];
          div_quo <= {div_quo[XLEN-2:0], 1'b1};
        end else begin
          div_rem <= {div_rem[XLEN-2:0], div_quo[XLEN-1]};
          div_quo <= {div_quo[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  always_comb begin
    div_state_nxt = div_state;
    case (div_state)
      DIV_IDLE: if (div_start) div_state_nxt = (div_by_zero || div_ovf) ? DIV_DONE : DIV_RUN;
      DIV_RUN: begin
        if (ex_flush) div_state_nxt = DIV_IDLE;
        else if (div_cnt == CNT_W'(XLEN-1)) div_state_nxt = DIV_DONE;
      end
      DIV_DONE: if (ex_flush || !ex_stall_in) div_state_nxt = DIV_IDLE;
      default: div_state_nxt = DIV_IDLE;
    endcase
  end

  always_comb begin
    ex_busy = ((div_state == DIV_IDLE) && div_start) || (div_state == DIV_RUN);
    q_out   = div_q_neg ? -div_quo : div_quo;
    r_out   = div_r_neg ? -div_rem : div_rem;
    div_res = id_md_op[1] ? r_out : q_out;
  end

  assign ex_result_nxt = id_md_en ? (id_md_op[2] ? div_res : mul_res) : alu_res;
  assign load_valid    = id_valid & ~ex_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_reg_wen   <= 1'b0;
      ex_reg_waddr <= '0;
      ex_result    <= '0;
      ex_ill_instr <= 1'b0;
    end else if (ex_flush) begin
      ex_valid     <= 1'b0;
      ex_reg_wen   <= 1'b0;
      ex_ill_instr <= 1'b0;
    end else if (!ex_stall_in) begin
      ex_valid     <= load_valid;
      ex_reg_wen   <= id_reg_wen & load_valid;
      ex_reg_waddr <= id_reg_waddr;
      ex_result    <= ex_result_nxt;
      ex_ill_instr <= id_ill_instr & load_valid;
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Self-checking bench for ex_stage_md: reference-model scoreboard over ALU, MUL and
// DIV ops, plus divider latency, stall-in-DONE, flush and mid-divide reset.
module tb_ex_stage_md;
  localparam int XLEN = 32;
  localparam int RF_AW = 5;
  localparam int W = XLEN + RF_AW + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0, id_reg_wen = 1'b0, id_md_en = 1'b0, id_ill_instr = 1'b0;
  logic [RF_AW-1:0] id_reg_waddr = '0;
  logic [XLEN-1:0] id_rs1_data = '0, id_rs2_data = '0;
  logic [3:0] id_alu_op = '0;
  logic [2:0] id_md_op = '0;
  logic ex_flush = 1'b0, ex_stall_in = 1'b0;
  logic ex_busy, ex_valid, ex_reg_wen, ex_ill_instr;
  logic [RF_AW-1:0] ex_reg_waddr;
  logic [XLEN-1:0] ex_result;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;

  ex_stage_md #(.XLEN(XLEN), .RF_AW(RF_AW), .ALU_OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_reg_wen(id_reg_wen),
    .id_reg_waddr(id_reg_waddr), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_alu_op(id_alu_op), .id_md_en(id_md_en), .id_md_op(id_md_op),
    .id_ill_instr(id_ill_instr), .ex_flush(ex_flush), .ex_stall_in(ex_stall_in),
    .ex_busy(ex_busy), .ex_valid(ex_valid), .ex_reg_wen(ex_reg_wen),
    .ex_reg_waddr(ex_reg_waddr), .ex_result(ex_result), .ex_ill_instr(ex_ill_instr)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a << b[4:0];
      4'd2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:  return (a < b) ? 32'd1 : 32'd0;
      4'd4:  return a ^ b;
      4'd5:  return a >> b[4:0];
      4'd6:  return a | b;
      4'd7:  return a & b;
      4'd8:  return a - b;
      4'd13: return 32'($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, b);
    logic signed [63:0] sp;
    logic [63:0] up;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: return a * b;
      3'd1: begin sp = 64'(sa) * 64'(sb); return sp[63:32]; end
      3'd2: begin sp = 64'(sa) * $signed({32'd0, b}); return sp[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      default: begin
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
        if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        return op[1] ? a % b : a / b;
      end
    endcase
  endfunction

  // Drives one instruction, counts busy cycles, checks bubbles, pops the result.
  // stall_cyc holds ex_stall_in high for that many cycles once the divider is done.
  task automatic run_op(input string tag, input logic md, input logic [2:0] mop,
                        input logic [3:0] aop, input logic [31:0] a, input logic [31:0] b,
                        input logic wen, input logic ill, input int exp_busy,
                        input int stall_cyc);
    logic [W-1:0] e;
    logic [RF_AW-1:0] wa;
    logic bz;
    int busy_cnt = 0;
    int st = stall_cyc;
    int guard = 0;
    logic [31:0] r;
    r = md ? ref_md(mop, a, b) : ref_alu(aop, a, b);
    wa = RF_AW'($urandom_range(1, 31));
    @(negedge clk);
    id_valid = 1'b1; id_md_en = md; id_md_op = mop; id_alu_op = aop;
    id_rs1_data = a; id_rs2_data = b; id_reg_wen = wen; id_ill_instr = ill;
    id_reg_waddr = wa;
    exp_q.push_back({ill, wen, wa, r});
    forever begin
      #1 bz = ex_busy;
      if (bz) busy_cnt++;
      else if (st > 0) begin ex_stall_in = 1'b1; st--; end
      else ex_stall_in = 1'b0;
      @(posedge clk);
      if (!bz && !ex_stall_in) break;
      @(negedge clk);
      check({tag, "_bubble"}, 64'(ex_valid), 64'd0);
      guard++;
      if (guard > 100) begin
        check({tag, "_timeout"}, 64'(guard), 64'd0);
        break;
      end
    end
    @(negedge clk);
    check({tag, "_valid"}, 64'(ex_valid), 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_result"}, 64'({ex_ill_instr, ex_reg_wen, ex_reg_waddr, ex_result}), 64'(e));
    end
    id_valid = 1'b0; ex_stall_in = 1'b0;
    @(negedge clk);
    check({tag, "_once"}, 64'(ex_valid), 64'd0);
  endtask

  function automatic int div_busy(input logic [2:0] op, input logic [31:0] a, b);
    if (!op[2]) return 0;
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return XLEN + 1;
  endfunction

  initial begin
    logic [3:0] alu_ops [10];
    logic [3:0] aop;
    logic [2:0] mop;
    logic [31:0] a, b;
    alu_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd13};

    repeat (3) @(negedge clk);
    check("rst_valid", 64'(ex_valid), 64'd0);
    check("rst_outs", 64'({ex_busy, ex_reg_wen, ex_ill_instr, ex_reg_waddr, ex_result}), 64'd0);
    rst_n = 1'b1;

    run_op("add", 1'b0, 3'd0, 4'd0, 32'd5, 32'd7, 1'b1, 1'b0, 0, 0);
    run_op("div_neg", 1'b1, 3'd4, 4'd0, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 33, 0);
    run_op("rem_neg", 1'b1, 3'd6, 4'd0, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 33, 0);
    run_op("divu_zero", 1'b1, 3'd5, 4'd0, 32'd100, 32'd0, 1'b1, 1'b0, 1, 0);
    run_op("remu_zero", 1'b1, 3'd7, 4'd0, 32'd100, 32'd0, 1'b1, 1'b0, 1, 0);
    run_op("div_ovf", 1'b1, 3'd4, 4'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1, 0);
    run_op("rem_ovf", 1'b1, 3'd6, 4'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1, 0);
    run_op("mul", 1'b1, 3'd0, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 0);
    run_op("mulh", 1'b1, 3'd1, 4'd0, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 0, 0);
    run_op("mulhsu", 1'b1, 3'd2, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 0);
    run_op("divu_max", 1'b1, 3'd5, 4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 33, 0);
    run_op("ill_sub", 1'b0, 3'd0, 4'd8, 32'd3, 32'd10, 1'b0, 1'b1, 0, 0);

    for (int i = 0; i < 12; i++) begin
      aop = alu_ops[$urandom_range(0, 9)];
      run_op("rand_alu", 1'b0, 3'd0, aop, $urandom, $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    end
    for (int i = 0; i < 10; i++) begin
      mop = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 2 == 0 && mop[2] && !mop[0]) b = -b;
      run_op("rand_md", 1'b1, mop, 4'd0, a, b, 1'b1, 1'b0, div_busy(mop, a, b), 0);
    end

    run_op("stall_done", 1'b1, 3'd5, 4'd0, 32'd50, 32'd7, 1'b1, 1'b0, 33, 3);

    // flush at cycle 10 of a divide
    @(negedge clk);
    id_valid = 1'b1; id_md_en = 1'b1; id_md_op = 3'd4; id_rs1_data = 32'd1000;
    id_rs2_data = 32'd3; id_reg_wen = 1'b1; id_ill_instr = 1'b0;
    for (int c = 1; c < 10; c++) begin
      #1 check("flush_pre_busy", 64'(ex_busy), 64'd1);
      @(negedge clk);
    end
    #1 check("flush_c10_busy", 64'(ex_busy), 64'd1);
    ex_flush = 1'b1;
    @(negedge clk);
    check("flush_valid", 64'(ex_valid), 64'd0);
    id_valid = 1'b0; ex_flush = 1'b0;
    #1 check("flush_busy_drop", 64'(ex_busy), 64'd0);
    @(negedge clk);
    check("flush_no_result", 64'(ex_valid), 64'd0);
    run_op("add_after_flush", 1'b0, 3'd0, 4'd0, 32'd30, 32'd12, 1'b1, 1'b0, 0, 0);

    // leave nonzero EX registers, then reset mid-divide
    @(negedge clk);
    id_valid = 1'b1; id_md_en = 1'b0; id_alu_op = 4'd0; id_rs1_data = 32'd9;
    id_rs2_data = 32'd9; id_reg_wen = 1'b1; id_reg_waddr = 5'd7; id_ill_instr = 1'b1;
    @(negedge clk);
    check("pre_rst_valid", 64'(ex_valid), 64'd1);
    id_md_en = 1'b1; id_md_op = 3'd4; id_rs1_data = 32'd77; id_rs2_data = 32'd5;
    repeat (5) @(negedge clk);
    check("mid_div_busy", 64'(ex_busy), 64'd1);
    rst_n = 1'b0;
    #1 check("rst_mid_div",
             64'({ex_busy, ex_valid, ex_reg_wen, ex_ill_instr, ex_reg_waddr, ex_result}), 64'd0);
    id_valid = 1'b0; id_ill_instr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("add_after_rst", 1'b0, 3'd0, 4'd0, 32'd5, 32'd7, 1'b1, 1'b0, 0, 0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end
endmodule
